// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial bus transmit path.
package serial_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    TX   = 1'b1
  } tx_state_e;

  localparam bit LSB_FIRST_C = 1'b0;
  localparam bit MSB_FIRST_C = 1'b1;

endpackage

// File: rtl/slave_out_port_burst_if.sv
// Word-in / serial-out handshake bundle of the slave transmit port.
interface slave_out_port_burst_if #(
  parameter int DATA_W = 8
);

  logic              s_valid;
  logic [DATA_W-1:0] data_input;
  logic              s_ready;
  logic              m_ready;
  logic              tx_data;
  logic              tx_valid;
  logic              s_tx_done;
  logic              burst_done;

  modport slave (
    input  s_valid, data_input, m_ready,
    output s_ready, tx_data, tx_valid, s_tx_done, burst_done
  );

  modport master (
    output s_valid, data_input, m_ready,
    input  s_ready, tx_data, tx_valid, s_tx_done, burst_done
  );

endinterface

// File: rtl/serial_bus_fifo.sv
// Generic synchronous FIFO; rdata shows the head combinationally, push ignored when full.
module serial_bus_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/slave_out_port_burst.sv
// Buffered serial transmit port: words shift out one bit per clk, back-to-back while data and m_ready allow.
// First bit appears one edge after a push into an empty idle port; s_ready drops only when the buffer is full.
module slave_out_port_burst
  import serial_bus_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = LSB_FIRST_C,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  slave_out_port_burst_if.slave  bus
);

  localparam int BW = $clog2(DATA_W);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W-1);

  tx_state_e         state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              tx_data_r;
  logic              tx_valid_r;
  logic              done_r;
  logic              burst_done_r;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST == MSB_FIRST_C) ? w[DATA_W-1] : w[0];
  endfunction

  assign bus.s_ready    = !reset && (count != CW'(FIFO_DEPTH));
  assign bus.tx_data    = tx_data_r;
  assign bus.tx_valid   = tx_valid_r;
  assign bus.s_tx_done  = done_r;
  assign bus.burst_done = burst_done_r;

  assign push = bus.s_valid && !full;
  // A new word is taken only from IDLE or while the previous word's last bit is on the line.
  assign pop  = !empty && bus.m_ready && ((state == IDLE) || done_r);

  assign shifted = (MSB_FIRST == MSB_FIRST_C) ? {shreg[DATA_W-2:0], 1'b0}
                                              : {1'b0, shreg[DATA_W-1:1]};

  serial_bus_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.data_input),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      tx_data_r    <= IDLE_LEVEL;
      tx_valid_r   <= 1'b0;
      done_r       <= 1'b0;
      burst_done_r <= 1'b0;
    end else begin
      done_r       <= 1'b0;
      burst_done_r <= 1'b0;
      if (pop) begin
        state      <= TX;
        shreg      <= head;
        tx_data_r  <= first_bit(head);
        tx_valid_r <= 1'b1;
        bit_cnt    <= BW'(1);
      end else if ((state == IDLE) || done_r) begin
        state      <= IDLE;
        tx_data_r  <= IDLE_LEVEL;
        tx_valid_r <= 1'b0;
        bit_cnt    <= '0;
      end else begin
        shreg     <= shifted;
        tx_data_r <= first_bit(shifted);
        if (bit_cnt == LAST_BIT) begin
          done_r       <= 1'b1;
          burst_done_r <= empty || !bus.m_ready;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_slave_out_port_burst.sv
// Scoreboard bench: two ports (LSB-first/idle 0 and MSB-first/idle 1) share stimulus and a word-level model.
module tb_slave_out_port_burst;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] data_input = '0;
  logic          m_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  slave_out_port_burst_if #(.DATA_W(DW)) bus_a ();
  slave_out_port_burst_if #(.DATA_W(DW)) bus_b ();

  assign bus_a.s_valid    = s_valid;
  assign bus_a.data_input = data_input;
  assign bus_a.m_ready    = m_ready;
  assign bus_b.s_valid    = s_valid;
  assign bus_b.data_input = data_input;
  assign bus_b.m_ready    = m_ready;

  slave_out_port_burst #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  slave_out_port_burst #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Expected contents of one payload cycle: bit for each port order, word-end and burst-end flags.
  typedef struct packed {
    logic da;
    logic db;
    logic done;
    logic bdone;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_cur = '0;
  int            m_pos = -1;

  task automatic chk(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered words plus the index of the bit on the line (-1 = idle).
  always @(posedge clk or posedge reset) begin : model
    bit   accept;
    bit   bd;
    exp_t e;
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_pos = -1;
    end else begin
      accept = s_valid && (m_q.size() < DEPTH);
      if (m_pos < 0 || m_pos == DW-1) begin
        if (m_q.size() > 0 && m_ready) begin
          m_cur = m_q.pop_front();
          m_pos = 0;
        end else begin
          m_pos = -1;
        end
      end else begin
        m_pos++;
      end
      bd = (m_q.size() == 0) || !m_ready;
      if (accept) m_q.push_back(data_input);
      if (m_pos >= 0) begin
        e.da    = m_cur[m_pos];
        e.db    = m_cur[DW-1-m_pos];
        e.done  = (m_pos == DW-1);
        e.bdone = e.done && bd;
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic exp_rdy;
    exp_t e;
    exp_rdy = !reset && (m_q.size() < DEPTH);
    chk("s_ready_a", bus_a.s_ready, exp_rdy);
    chk("s_ready_b", bus_b.s_ready, exp_rdy);
    chk("tx_valid_a", bus_a.tx_valid, m_pos >= 0);
    chk("tx_valid_b", bus_b.tx_valid, m_pos >= 0);
    if (bus_a.tx_valid || bus_b.tx_valid) begin
      chk("exp_available", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data_a", bus_a.tx_data, e.da);
        chk("tx_data_b", bus_b.tx_data, e.db);
        chk("s_tx_done_a", bus_a.s_tx_done, e.done);
        chk("s_tx_done_b", bus_b.s_tx_done, e.done);
        chk("burst_done_a", bus_a.burst_done, e.bdone);
        chk("burst_done_b", bus_b.burst_done, e.bdone);
      end
    end else begin
      chk("idle_level_a", bus_a.tx_data, 1'b0);
      chk("idle_level_b", bus_b.tx_data, 1'b1);
      chk("idle_done_a", bus_a.s_tx_done | bus_a.burst_done, 1'b0);
      chk("idle_done_b", bus_b.s_tx_done | bus_b.burst_done, 1'b0);
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic mr);
    s_valid    = v;
    data_input = d;
    m_ready    = mr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b0;

    // Single word 0x12.
    cyc(1'b1, 8'h12, 1'b1);
    repeat (10) cyc(1'b0, '0, 1'b1);

    // Burst of three words.
    cyc(1'b1, 8'hFF, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'hAA, 1'b1);
    repeat (28) cyc(1'b0, '0, 1'b1);

    // Fill with master not ready; fifth word refused.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h30 + i), 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0);
    repeat (36) cyc(1'b0, '0, 1'b1);

    // Reset while bit 3 of 0xA5 is on the line with two words queued.
    cyc(1'b1, 8'hA5, 1'b1);
    cyc(1'b1, 8'h11, 1'b1);
    cyc(1'b1, 8'h22, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    reset = 1'b1;
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    reset = 1'b0;
    repeat (12) cyc(1'b0, '0, 1'b1);

    // Master drops ready mid-word with a second word queued.
    cyc(1'b1, 8'hC3, 1'b1);
    cyc(1'b1, 8'h3C, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    repeat (15) cyc(1'b0, '0, 1'b0);
    repeat (12) cyc(1'b0, '0, 1'b1);

    // Random traffic with random master readiness.
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 99) < 60), DW'($urandom), ($urandom_range(0, 99) < 80));

    n = 0;
    while ((m_pos >= 0 || m_q.size() > 0) && n < 200) begin
      cyc(1'b0, '0, 1'b1);
      n++;
    end
    chk("drain_timeout", n < 200, 1'b1);
    repeat (2) cyc(1'b0, '0, 1'b1);
    chk("exp_q_empty", exp_q.size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
